// File: rtl/axi_defs.sv
// Shared definitions for the CPU sram-like to AXI bridge: bus widths, default IDs,
// fixed AXI attribute values and the read/write FSM state encodings.
package axi_defs;

    localparam int unsigned ADDR_W = 32;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned ID_W   = 4;
    localparam int unsigned STRB_W = DATA_W / 8;

    localparam logic [ID_W-1:0] DEF_ID_INST = 4'd0;
    localparam logic [ID_W-1:0] DEF_ID_DATA = 4'd1;

    // Single-beat, non-cached, non-privileged transfers only
    localparam logic [3:0] AXI_LEN_SINGLE  = 4'd0;
    localparam logic [1:0] AXI_BURST_INCR  = 2'b01;
    localparam logic [1:0] AXI_LOCK_NORMAL = 2'b00;
    localparam logic [3:0] AXI_CACHE_NONE  = 4'd0;
    localparam logic [2:0] AXI_PROT_NONE   = 3'd0;

    typedef enum logic [1:0] {
        RD_IDLE = 2'd0,
        RD_AR   = 2'd1,
        RD_R    = 2'd2
    } rd_state_e;

    typedef enum logic [1:0] {
        WR_IDLE = 2'd0,
        WR_AWW  = 2'd1,
        WR_B    = 2'd2
    } wr_state_e;

endpackage

// File: rtl/cpu_axi_bridge_if.sv
// AXI3 master bus between the bridge and the memory system.
// master: bridge side (drives AR/AW/W, rready, bready)
// slave : memory side (drives arready, R channel, awready, wready, bvalid)
interface cpu_axi_bridge_if;
    import axi_defs::*;

    logic [ID_W-1:0]   arid;
    logic [ADDR_W-1:0] araddr;
    logic [3:0]        arlen;
    logic [2:0]        arsize;
    logic [1:0]        arburst;
    logic [1:0]        arlock;
    logic [3:0]        arcache;
    logic [2:0]        arprot;
    logic              arvalid;
    logic              arready;

    logic [ID_W-1:0]   rid;
    logic [DATA_W-1:0] rdata;
    logic              rvalid;
    logic              rready;

    logic [ID_W-1:0]   awid;
    logic [ADDR_W-1:0] awaddr;
    logic [3:0]        awlen;
    logic [2:0]        awsize;
    logic [1:0]        awburst;
    logic [1:0]        awlock;
    logic [3:0]        awcache;
    logic [2:0]        awprot;
    logic              awvalid;
    logic              awready;

    logic [ID_W-1:0]   wid;
    logic [DATA_W-1:0] wdata;
    logic [STRB_W-1:0] wstrb;
    logic              wlast;
    logic              wvalid;
    logic              wready;

    logic              bvalid;
    logic              bready;

    modport master (
        output arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arvalid,
        input  arready,
        input  rid, rdata, rvalid,
        output rready,
        output awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awvalid,
        input  awready,
        output wid, wdata, wstrb, wlast, wvalid,
        input  wready,
        input  bvalid,
        output bready
    );

    modport slave (
        input  arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arvalid,
        output arready,
        output rid, rdata, rvalid,
        input  rready,
        input  awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awvalid,
        output awready,
        input  wid, wdata, wstrb, wlast, wvalid,
        output wready,
        output bvalid,
        input  bready
    );

endinterface

// File: rtl/sram_strb_gen.sv
// Decodes an sram-like size/byte offset into AXI transfer size and write strobes.
// Ports: i_size (0=byte,1=half,2=word), i_addr_lo (addr[1:0]),
//        o_axsize_c (AXI size), o_wstrb_c (byte lane enables).
module sram_strb_gen
    import axi_defs::*;
(
    input  logic [1:0]        i_size,
    input  logic [1:0]        i_addr_lo,
    output logic [2:0]        o_axsize_c,
    output logic [STRB_W-1:0] o_wstrb_c
);

    // Size 3 is undefined on the CPU side; treat it as a full word
    always_comb begin
        o_axsize_c = 3'd2;
        o_wstrb_c  = 4'b1111;
        case (i_size)
            2'd0: begin
                o_axsize_c = 3'd0;
                o_wstrb_c  = 4'(4'b0001 << i_addr_lo);
            end
            2'd1: begin
                o_axsize_c = 3'd1;
                o_wstrb_c  = 4'(4'b0011 << i_addr_lo);
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/cpu_axi_bridge.sv
// Bridges an instruction and a data sram-like port onto one AXI3 master.
// One outstanding read (inst or data, tagged by ID) and one outstanding write (data only).
// Ports: clk/resetn (sync active-low), inst_sram_* and data_sram_* CPU ports
//        (addrok combinational handshake, dataok registered pulse), axi master bus.
module cpu_axi_bridge
    import axi_defs::*;
#(
    parameter logic [ID_W-1:0] ID_INST = DEF_ID_INST,
    parameter logic [ID_W-1:0] ID_DATA = DEF_ID_DATA
) (
    input  logic              clk,
    input  logic              resetn,

    input  logic              inst_sram_req,
    input  logic              inst_sram_wr,
    input  logic [1:0]        inst_sram_size,
    input  logic [ADDR_W-1:0] inst_sram_addr,
    input  logic [DATA_W-1:0] inst_sram_wdata,
    output logic [DATA_W-1:0] inst_sram_rdata,
    output logic              inst_sram_addrok,
    output logic              inst_sram_dataok,

    input  logic              data_sram_req,
    input  logic              data_sram_wr,
    input  logic [1:0]        data_sram_size,
    input  logic [ADDR_W-1:0] data_sram_addr,
    input  logic [DATA_W-1:0] data_sram_wdata,
    output logic [DATA_W-1:0] data_sram_rdata,
    output logic              data_sram_addrok,
    output logic              data_sram_dataok,

    cpu_axi_bridge_if.master  axi
);

    rd_state_e         r_rd_state, w_rd_next;
    wr_state_e         r_wr_state, w_wr_next;

    logic [ID_W-1:0]   r_arid;
    logic [ADDR_W-1:0] r_araddr;
    logic [2:0]        r_arsize;
    logic              r_arvalid, r_rready;
    logic [DATA_W-1:0] r_rdata;
    logic              r_inst_dataok;

    logic [ADDR_W-1:0] r_awaddr;
    logic [2:0]        r_awsize;
    logic [DATA_W-1:0] r_wdata;
    logic [STRB_W-1:0] r_wstrb;
    logic              r_awvalid, r_wvalid, r_bready;
    logic              r_data_dataok, r_wr_ok_pend;

    logic              w_data_rd_req, w_inst_rd_req, w_raw_hazard;
    logic              w_data_rd_go, w_inst_rd_go, w_data_wr_go;
    logic [1:0]        w_rd_size;
    logic [ADDR_W-1:0] w_rd_addr;
    logic [2:0]        w_rd_axsize, w_wr_axsize;
    logic [STRB_W-1:0] w_wr_wstrb, w_rd_strb_unused;
    logic              w_r_hs, w_aw_hs, w_w_hs, w_b_hs;
    logic              w_rd_data_ok, w_wr_ok;
    logic              w_unused;

    // Request acceptance; data read beats inst read, and a data read must not pass
    // an unfinished write to the same word
    assign w_data_rd_req = data_sram_req & ~data_sram_wr;
    assign w_inst_rd_req = inst_sram_req & ~inst_sram_wr;
    assign w_raw_hazard  = (r_wr_state != WR_IDLE) && (r_awaddr[31:2] == data_sram_addr[31:2]);
    assign w_data_rd_go  = resetn & w_data_rd_req & (r_rd_state == RD_IDLE) & ~w_raw_hazard;
    assign w_inst_rd_go  = resetn & w_inst_rd_req & (r_rd_state == RD_IDLE) & ~w_data_rd_req;
    assign w_data_wr_go  = resetn & data_sram_req & data_sram_wr & (r_wr_state == WR_IDLE);

    assign inst_sram_addrok = w_inst_rd_go;
    assign data_sram_addrok = w_data_rd_go | w_data_wr_go;

    assign w_rd_size = w_data_rd_req ? data_sram_size : inst_sram_size;
    assign w_rd_addr = w_data_rd_req ? data_sram_addr : inst_sram_addr;

    sram_strb_gen u_rd_strb (
        .i_size     (w_rd_size),
        .i_addr_lo  (w_rd_addr[1:0]),
        .o_axsize_c (w_rd_axsize),
        .o_wstrb_c  (w_rd_strb_unused)
    );

    sram_strb_gen u_wr_strb (
        .i_size     (data_sram_size),
        .i_addr_lo  (data_sram_addr[1:0]),
        .o_axsize_c (w_wr_axsize),
        .o_wstrb_c  (w_wr_wstrb)
    );

    assign w_r_hs  = r_rready & axi.rvalid;
    assign w_aw_hs = r_awvalid & axi.awready;
    assign w_w_hs  = r_wvalid & axi.wready;
    assign w_b_hs  = r_bready & axi.bvalid;

    // Read FSM next state
    always_comb begin
        w_rd_next = r_rd_state;
        unique case (r_rd_state)
            RD_IDLE: if (w_data_rd_go | w_inst_rd_go) w_rd_next = RD_AR;
            RD_AR:   if (axi.arready)                 w_rd_next = RD_R;
            RD_R:    if (axi.rvalid)                  w_rd_next = RD_IDLE;
            default:                                  w_rd_next = RD_IDLE;
        endcase
    end

    // Read FSM state, AR payload and read response registers
    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_rd_state    <= RD_IDLE;
            r_arvalid     <= 1'b0;
            r_rready      <= 1'b0;
            r_arid        <= '0;
            r_araddr      <= '0;
            r_arsize      <= '0;
            r_rdata       <= '0;
            r_inst_dataok <= 1'b0;
        end else begin
            r_rd_state    <= w_rd_next;
            r_arvalid     <= (w_rd_next == RD_AR);
            r_rready      <= (w_rd_next == RD_R);
            if (w_data_rd_go | w_inst_rd_go) begin
                r_arid   <= w_data_rd_go ? ID_DATA : ID_INST;
                r_araddr <= w_rd_addr;
                r_arsize <= w_rd_axsize;
            end
            if (w_r_hs) r_rdata <= axi.rdata;
            r_inst_dataok <= w_r_hs & (axi.rid == ID_INST);
        end
    end

    // Write FSM next state; AW and W may complete in either order
    always_comb begin
        w_wr_next = r_wr_state;
        unique case (r_wr_state)
            WR_IDLE: if (w_data_wr_go) w_wr_next = WR_AWW;
            WR_AWW:  if ((~r_awvalid | w_aw_hs) & (~r_wvalid | w_w_hs)) w_wr_next = WR_B;
            WR_B:    if (axi.bvalid)  w_wr_next = WR_IDLE;
            default:                  w_wr_next = WR_IDLE;
        endcase
    end

    // Write FSM state and AW/W payload registers
    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_wr_state <= WR_IDLE;
            r_awvalid  <= 1'b0;
            r_wvalid   <= 1'b0;
            r_bready   <= 1'b0;
            r_awaddr   <= '0;
            r_awsize   <= '0;
            r_wdata    <= '0;
            r_wstrb    <= '0;
        end else begin
            r_wr_state <= w_wr_next;
            r_bready   <= (w_wr_next == WR_B);
            if (w_data_wr_go) begin
                r_awvalid <= 1'b1;
                r_wvalid  <= 1'b1;
                r_awaddr  <= data_sram_addr;
                r_awsize  <= w_wr_axsize;
                r_wdata   <= data_sram_wdata;
                r_wstrb   <= w_wr_wstrb;
            end else begin
                if (w_aw_hs) r_awvalid <= 1'b0;
                if (w_w_hs)  r_wvalid  <= 1'b0;
            end
        end
    end

    // Data-port dataok: a read completion wins the slot, a colliding write waits one cycle
    assign w_rd_data_ok = w_r_hs & (axi.rid == ID_DATA);
    assign w_wr_ok      = w_b_hs | r_wr_ok_pend;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_data_dataok <= 1'b0;
            r_wr_ok_pend  <= 1'b0;
        end else begin
            r_data_dataok <= w_rd_data_ok | w_wr_ok;
            r_wr_ok_pend  <= w_rd_data_ok & w_wr_ok;
        end
    end

    assign inst_sram_rdata  = r_rdata;
    assign inst_sram_dataok = r_inst_dataok;
    assign data_sram_rdata  = r_rdata;
    assign data_sram_dataok = r_data_dataok;

    assign axi.arid    = r_arid;
    assign axi.araddr  = r_araddr;
    assign axi.arlen   = AXI_LEN_SINGLE;
    assign axi.arsize  = r_arsize;
    assign axi.arburst = AXI_BURST_INCR;
    assign axi.arlock  = AXI_LOCK_NORMAL;
    assign axi.arcache = AXI_CACHE_NONE;
    assign axi.arprot  = AXI_PROT_NONE;
    assign axi.arvalid = r_arvalid;
    assign axi.rready  = r_rready;

    assign axi.awid    = ID_DATA;
    assign axi.awaddr  = r_awaddr;
    assign axi.awlen   = AXI_LEN_SINGLE;
    assign axi.awsize  = r_awsize;
    assign axi.awburst = AXI_BURST_INCR;
    assign axi.awlock  = AXI_LOCK_NORMAL;
    assign axi.awcache = AXI_CACHE_NONE;
    assign axi.awprot  = AXI_PROT_NONE;
    assign axi.awvalid = r_awvalid;

    assign axi.wid     = ID_DATA;
    assign axi.wdata   = r_wdata;
    assign axi.wstrb   = r_wstrb;
    assign axi.wlast   = 1'b1;
    assign axi.wvalid  = r_wvalid;
    assign axi.bready  = r_bready;

    // Instruction writes are never accepted, so their data and the read-side strobes are dead
    assign w_unused = ^{inst_sram_wdata, w_rd_strb_unused};

endmodule

// File: tb/tb_cpu_axi_bridge.sv
// Directed self-checking bench for cpu_axi_bridge; the bench plays the AXI slave.
module tb_cpu_axi_bridge;

    logic        clk = 1'b0;
    logic        resetn;
    logic        inst_sram_req, inst_sram_wr;
    logic [1:0]  inst_sram_size;
    logic [31:0] inst_sram_addr, inst_sram_wdata, inst_sram_rdata;
    logic        inst_sram_addrok, inst_sram_dataok;
    logic        data_sram_req, data_sram_wr;
    logic [1:0]  data_sram_size;
    logic [31:0] data_sram_addr, data_sram_wdata, data_sram_rdata;
    logic        data_sram_addrok, data_sram_dataok;

    int n_checks = 0;
    int n_errors = 0;

    cpu_axi_bridge_if axi ();

    cpu_axi_bridge #(.ID_INST(4'd0), .ID_DATA(4'd1)) dut (
        .clk              (clk),
        .resetn           (resetn),
        .inst_sram_req    (inst_sram_req),
        .inst_sram_wr     (inst_sram_wr),
        .inst_sram_size   (inst_sram_size),
        .inst_sram_addr   (inst_sram_addr),
        .inst_sram_wdata  (inst_sram_wdata),
        .inst_sram_rdata  (inst_sram_rdata),
        .inst_sram_addrok (inst_sram_addrok),
        .inst_sram_dataok (inst_sram_dataok),
        .data_sram_req    (data_sram_req),
        .data_sram_wr     (data_sram_wr),
        .data_sram_size   (data_sram_size),
        .data_sram_addr   (data_sram_addr),
        .data_sram_wdata  (data_sram_wdata),
        .data_sram_rdata  (data_sram_rdata),
        .data_sram_addrok (data_sram_addrok),
        .data_sram_dataok (data_sram_dataok),
        .axi              (axi.master)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", tag, act, exp, $time);
        end
    endtask

    // Advance one clock; inputs change and outputs are sampled 1ns after the edge
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic ar_accept();
        axi.arready = 1'b1;
        step();
        axi.arready = 1'b0;
    endtask

    task automatic r_return(input logic [3:0] id, input logic [31:0] data);
        axi.rvalid = 1'b1;
        axi.rid    = id;
        axi.rdata  = data;
        step();
        axi.rvalid = 1'b0;
    endtask

    task automatic data_req(input logic wr, input logic [1:0] size,
                            input logic [31:0] addr, input logic [31:0] wdata);
        data_sram_req   = 1'b1;
        data_sram_wr    = wr;
        data_sram_size  = size;
        data_sram_addr  = addr;
        data_sram_wdata = wdata;
        #1;
    endtask

    initial begin
        resetn = 1'b0;
        inst_sram_req = 0; inst_sram_wr = 0; inst_sram_size = 2'd2;
        inst_sram_addr = '0; inst_sram_wdata = '0;
        data_sram_req = 0; data_sram_wr = 0; data_sram_size = 2'd2;
        data_sram_addr = '0; data_sram_wdata = '0;
        axi.arready = 0; axi.rid = '0; axi.rdata = '0; axi.rvalid = 0;
        axi.awready = 0; axi.wready = 0; axi.bvalid = 0;

        // Reset state
        repeat (3) step();
        check_eq("rst_arvalid", 32'(axi.arvalid), 32'd0);
        check_eq("rst_rready",  32'(axi.rready),  32'd0);
        check_eq("rst_awvalid", 32'(axi.awvalid), 32'd0);
        check_eq("rst_wvalid",  32'(axi.wvalid),  32'd0);
        check_eq("rst_bready",  32'(axi.bready),  32'd0);
        check_eq("rst_dataok",  32'({inst_sram_dataok, data_sram_dataok}), 32'd0);
        check_eq("rst_araddr",  axi.araddr, 32'd0);
        resetn = 1'b1;
        step();

        // Instruction read with arready late by 2 cycles; stray rvalid in RD_AR ignored
        inst_sram_req = 1; inst_sram_size = 2'd2; inst_sram_addr = 32'hBFC0_0000;
        #1;
        check_eq("ir_addrok", 32'(inst_sram_addrok), 32'd1);
        step();
        inst_sram_req = 0;
        check_eq("ir_arvalid", 32'(axi.arvalid), 32'd1);
        check_eq("ir_araddr",  axi.araddr, 32'hBFC0_0000);
        check_eq("ir_arid",    32'(axi.arid), 32'd0);
        check_eq("ir_arsize",  32'(axi.arsize), 32'd2);
        r_return(4'd0, 32'hDEAD_BEEF);
        check_eq("ir_stray_r", 32'(inst_sram_dataok), 32'd0);
        check_eq("ir_ar_hold", axi.araddr, 32'hBFC0_0000);
        step();
        check_eq("ir_ar_hold2", 32'(axi.arvalid), 32'd1);
        ar_accept();
        check_eq("ir_ar_drop", 32'(axi.arvalid), 32'd0);
        check_eq("ir_rready",  32'(axi.rready), 32'd1);
        r_return(4'd0, 32'h3C1D_8000);
        check_eq("ir_dataok", 32'(inst_sram_dataok), 32'd1);
        check_eq("ir_rdata",  inst_sram_rdata, 32'h3C1D_8000);
        check_eq("ir_no_ddok", 32'(data_sram_dataok), 32'd0);
        check_eq("ir_rready0", 32'(axi.rready), 32'd0);
        step();
        check_eq("ir_dataok_pulse", 32'(inst_sram_dataok), 32'd0);

        // Simultaneous inst and data reads: data first
        inst_sram_req = 1; inst_sram_addr = 32'hBFC0_0004;
        data_req(1'b0, 2'd2, 32'h8000_0010, 32'd0);
        check_eq("pri_d_addrok", 32'(data_sram_addrok), 32'd1);
        check_eq("pri_i_addrok", 32'(inst_sram_addrok), 32'd0);
        step();
        data_sram_req = 0;
        #1;
        check_eq("pri_arid",    32'(axi.arid), 32'd1);
        check_eq("pri_araddr",  axi.araddr, 32'h8000_0010);
        check_eq("pri_i_wait",  32'(inst_sram_addrok), 32'd0);
        ar_accept();
        check_eq("pri_i_wait_r", 32'(inst_sram_addrok), 32'd0);
        r_return(4'd1, 32'h1111_2222);
        check_eq("pri_d_dataok", 32'(data_sram_dataok), 32'd1);
        check_eq("pri_d_rdata",  data_sram_rdata, 32'h1111_2222);
        check_eq("pri_i_nodok",  32'(inst_sram_dataok), 32'd0);
        check_eq("pri_i_addrok2", 32'(inst_sram_addrok), 32'd1);
        step();
        inst_sram_req = 0;
        check_eq("pri_arid2",   32'(axi.arid), 32'd0);
        check_eq("pri_araddr2", axi.araddr, 32'hBFC0_0004);
        ar_accept();
        r_return(4'd0, 32'h0000_0055);
        check_eq("pri_i_dataok", 32'(inst_sram_dataok), 32'd1);
        check_eq("pri_i_rdata",  inst_sram_rdata, 32'h0000_0055);

        // Instruction write is rejected
        inst_sram_req = 1; inst_sram_wr = 1; inst_sram_addr = 32'hBFC0_0100;
        #1;
        check_eq("iw_addrok", 32'(inst_sram_addrok), 32'd0);
        step();
        inst_sram_req = 0; inst_sram_wr = 0;
        check_eq("iw_arvalid", 32'(axi.arvalid), 32'd0);
        check_eq("iw_awvalid", 32'(axi.awvalid), 32'd0);

        // Store byte to 0x80000003
        data_req(1'b1, 2'd0, 32'h8000_0003, 32'h0000_00AB);
        check_eq("sb_addrok", 32'(data_sram_addrok), 32'd1);
        step();
        data_sram_req = 0;
        check_eq("sb_awvalid", 32'(axi.awvalid), 32'd1);
        check_eq("sb_wvalid",  32'(axi.wvalid),  32'd1);
        check_eq("sb_awaddr",  axi.awaddr, 32'h8000_0003);
        check_eq("sb_awsize",  32'(axi.awsize), 32'd0);
        check_eq("sb_wstrb",   32'(axi.wstrb), 32'h8);
        check_eq("sb_wdata",   axi.wdata, 32'h0000_00AB);
        check_eq("sb_consts",  32'({axi.awlen, axi.awburst, axi.wlast, axi.wid, axi.awid}),
                 32'({4'd0, 2'b01, 1'b1, 4'd1, 4'd1}));
        axi.awready = 1; axi.wready = 1;
        step();
        axi.awready = 0; axi.wready = 0;
        check_eq("sb_aw_drop", 32'({axi.awvalid, axi.wvalid}), 32'd0);
        check_eq("sb_bready",  32'(axi.bready), 32'd1);
        step();
        check_eq("sb_no_dok",  32'(data_sram_dataok), 32'd0);
        axi.bvalid = 1;
        step();
        axi.bvalid = 0;
        check_eq("sb_dataok",  32'(data_sram_dataok), 32'd1);
        check_eq("sb_bready0", 32'(axi.bready), 32'd0);
        step();
        check_eq("sb_dataok_pulse", 32'(data_sram_dataok), 32'd0);

        // awready three cycles ahead of wready
        data_req(1'b1, 2'd2, 32'h8000_0020, 32'h1234_5678);
        step();
        data_sram_req = 0;
        check_eq("aw_wstrb",  32'(axi.wstrb), 32'hF);
        check_eq("aw_awsize", 32'(axi.awsize), 32'd2);
        axi.awready = 1;
        step();
        axi.awready = 0;
        check_eq("aw_awvalid0", 32'(axi.awvalid), 32'd0);
        check_eq("aw_wvalid1",  32'(axi.wvalid), 32'd1);
        step();
        step();
        check_eq("aw_wvalid_hold", 32'(axi.wvalid), 32'd1);
        check_eq("aw_wdata_hold",  axi.wdata, 32'h1234_5678);
        check_eq("aw_no_bready",   32'(axi.bready), 32'd0);
        axi.wready = 1;
        step();
        axi.wready = 0;
        check_eq("aw_wvalid0", 32'(axi.wvalid), 32'd0);
        check_eq("aw_bready",  32'(axi.bready), 32'd1);
        axi.bvalid = 1;
        step();
        axi.bvalid = 0;
        check_eq("aw_dataok", 32'(data_sram_dataok), 32'd1);
        step();
        check_eq("aw_dataok_pulse", 32'(data_sram_dataok), 32'd0);

        // Load after store to the same word stalls until the write completes
        data_req(1'b1, 2'd2, 32'h8000_0100, 32'hCAFE_F00D);
        step();
        data_sram_req = 0;
        axi.awready = 1; axi.wready = 1;
        step();
        axi.awready = 0; axi.wready = 0;
        data_req(1'b0, 2'd2, 32'h8000_0100, 32'd0);
        check_eq("raw_stall", 32'(data_sram_addrok), 32'd0);
        step();
        check_eq("raw_stall2",  32'(data_sram_addrok), 32'd0);
        check_eq("raw_arvalid", 32'(axi.arvalid), 32'd0);
        axi.bvalid = 1;
        step();
        axi.bvalid = 0;
        check_eq("raw_wr_dok", 32'(data_sram_dataok), 32'd1);
        check_eq("raw_release", 32'(data_sram_addrok), 32'd1);
        step();
        data_sram_req = 0;
        check_eq("raw_araddr", axi.araddr, 32'h8000_0100);
        check_eq("raw_arid",   32'(axi.arid), 32'd1);
        ar_accept();
        r_return(4'd1, 32'hCAFE_F00D);
        check_eq("raw_rd_dok", 32'(data_sram_dataok), 32'd1);
        check_eq("raw_rdata",  data_sram_rdata, 32'hCAFE_F00D);

        // Read and write completions in the same cycle: write dataok slips one cycle
        data_req(1'b0, 2'd2, 32'h8000_0200, 32'd0);
        step();
        data_sram_req = 0;
        ar_accept();
        data_req(1'b1, 2'd1, 32'h8000_0302, 32'h0000_BEEF);
        check_eq("col_wr_addrok", 32'(data_sram_addrok), 32'd1);
        step();
        data_sram_req = 0;
        check_eq("col_wstrb", 32'(axi.wstrb), 32'hC);
        check_eq("col_awsize", 32'(axi.awsize), 32'd1);
        axi.awready = 1; axi.wready = 1;
        step();
        axi.awready = 0; axi.wready = 0;
        axi.bvalid = 1;
        r_return(4'd1, 32'hA5A5_A5A5);
        axi.bvalid = 0;
        check_eq("col_dok1",  32'(data_sram_dataok), 32'd1);
        check_eq("col_rdata", data_sram_rdata, 32'hA5A5_A5A5);
        step();
        check_eq("col_dok2", 32'(data_sram_dataok), 32'd1);
        step();
        check_eq("col_dok3", 32'(data_sram_dataok), 32'd0);

        // Reset while waiting in RD_R
        inst_sram_req = 1; inst_sram_addr = 32'hBFC0_0008;
        step();
        inst_sram_req = 0;
        ar_accept();
        check_eq("rr_rready", 32'(axi.rready), 32'd1);
        resetn = 0;
        axi.rvalid = 1; axi.rid = 4'd0; axi.rdata = 32'h7777_7777;
        step();
        check_eq("rr_arvalid", 32'(axi.arvalid), 32'd0);
        check_eq("rr_rready0", 32'(axi.rready), 32'd0);
        check_eq("rr_no_dok",  32'(inst_sram_dataok), 32'd0);
        resetn = 1;
        step();
        axi.rvalid = 0;
        check_eq("rr_no_dok2", 32'({inst_sram_dataok, data_sram_dataok}), 32'd0);
        step();
        check_eq("rr_idle", 32'({axi.arvalid, axi.rready}), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/cpu_axi_bridge.md
CPU_AXI_BRIDGE -- requirements
Module: cpu_axi_bridge

Interface
REQ-001 SHALL have parameter ID_INST, default 4'd0, meaning the AXI ID tagging instruction reads.
REQ-002 SHALL have parameter ID_DATA, default 4'd1, meaning the AXI ID tagging data reads and writes.
REQ-003 SHALL have port clk  in  1  single clock; all state updates on posedge.
REQ-004 SHALL have port resetn  in  1  synchronous active-low reset.
REQ-005 SHALL have ports inst_sram_{req,wr,size,addr,wdata}  in  1/1/2/32/32  instruction sram-like request.
REQ-006 SHALL have ports inst_sram_{rdata,addrok,dataok}  out  32/1/1  instruction sram-like response.
REQ-007 SHALL have ports data_sram_{req,wr,size,addr,wdata}  in  1/1/2/32/32  data sram-like request.
REQ-008 SHALL have ports data_sram_{rdata,addrok,dataok}  out  32/1/1  data sram-like response.
REQ-009 SHALL have ports arid/araddr/arsize/arvalid  out  4/32/3/1, and arready  in  1  AXI read address.
REQ-010 SHALL have ports rid/rdata/rvalid  in  4/32/1, and rready  out  1  AXI read data.
REQ-011 SHALL have ports awid/awaddr/awsize/awvalid  out  4/32/3/1, and awready  in  1  AXI write address.
REQ-012 SHALL have ports wdata/wstrb/wvalid  out  32/4/1, wready  in  1, bvalid  in  1, bready  out  1  AXI write data/response.
REQ-013 SHALL drive constant arlen/awlen=0, burst=INCR, lock/cache/prot=0, wid=ID_DATA, wlast=1.

Function
REQ-014 SHALL run a read FSM RD_IDLE -> RD_AR (arvalid=1 until arready) -> RD_R (rready=1 until rvalid) -> RD_IDLE.
REQ-015 SHALL run a write FSM WR_IDLE -> WR_AWW (awvalid/wvalid held independently until each handshakes) -> WR_B (bready=1) -> WR_IDLE.
REQ-016 SHALL accept at most one outstanding read and one outstanding write; addrok asserted only in the cycle the request is latched.
REQ-017 SHALL give data-port read priority over inst-port read when both req in RD_IDLE; inst addrok=0 that cycle.
REQ-018 SHALL reject inst_sram_wr=1 (never addrok) as instruction writes are illegal.
REQ-019 SHALL stall a data read (addrok=0) whose addr[31:2] matches a write not yet in WR_IDLE.
REQ-020 SHALL map size 0/1/2 to arsize/awsize 0/1/2 and wstrb = 0001<<a, 0011<<a, 1111 respectively (a=addr[1:0]).
REQ-021 SHALL register rdata on rvalid&rready and pulse the port dataok selected by rid for exactly one cycle, next cycle.
REQ-022 SHALL pulse data_sram_dataok one cycle after bvalid&bready; if same cycle as a read dataok for data port, the write dataok SHALL be delayed one cycle.
REQ-023 SHALL present latched address/size/wdata stable on AXI while valid and not ready.
REQ-024 SHALL ignore rvalid/bvalid while not in RD_R/WR_B.

Reset
REQ-025 SHALL, on resetn=0 at posedge, set both FSMs to IDLE and all valid/ready/addrok/dataok outputs to 0, address/data registers to 0.
REQ-026 SHALL abandon any in-flight transaction on reset without issuing dataok.

Structure
REQ-027 SHALL place FSM state encodings, ID_INST/ID_DATA and AXI constant field values in shared package axi_defs.
REQ-028 SHALL factor wstrb/size decode into sub-module sram_strb_gen; FSMs remain in cpu_axi_bridge.

Verification
REQ-029 SHALL test inst read 0xBFC00000, arready after 2 cycles, rdata 0x3C1D8000 -> inst_sram_dataok one cycle, rdata 0x3C1D8000.
REQ-030 SHALL test simultaneous inst and data read requests -> arid=1 issued first, inst addrok only after RD_IDLE returns.
REQ-031 SHALL test sb to 0x80000003 data 0x000000AB -> awsize 0, wstrb 4'b1000, single dataok after bvalid.
REQ-032 SHALL test lw to 0x80000100 while sw to 0x80000100 awaits bvalid -> read addrok held 0 until write dataok.
REQ-033 SHALL test awready asserted 3 cycles before wready -> awvalid drops after handshake, wvalid held, one dataok.
REQ-034 SHALL test resetn=0 during RD_R -> arvalid/rready 0 next cycle, no dataok issued.
